// File: rtl/maze_mover.sv
// maze_mover: moves a TILE-square sprite through a tile maze once per frame,
// with wall lookup, horizontal tunnel wrap and a buffered pre-turn request.
module maze_mover #(
    parameter int TILE      = 16,
    parameter int COLS      = 30,
    parameter int ROWS      = 30,
    parameter int X_OFF     = 32,
    parameter int Y_OFF     = 0,
    parameter int START_X   = 272,
    parameter int START_Y   = 368,
    parameter int START_DIR = 3,
    parameter int STEP      = 1,
    parameter int TURN_HOLD = 8,
    parameter int WRAP_EN   = 1,
    parameter int WRAP_LO   = 16,
    parameter int WRAP_HI   = 512
) (
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic                 enable,
    input  logic [7:0]           keycode,
    input  logic [ROWS*COLS-1:0] maze_walls,
    output logic [9:0]           xpos,
    output logic [9:0]           ypos,
    output logic [2:0]           curDir,
    output logic                 move,
    output logic                 turn_pending,
    output logic                 wrapped
);
    localparam int TSH = $clog2(TILE);
    localparam int CW  = (TURN_HOLD < 1) ? 1 : $clog2(TURN_HOLD + 1);
    localparam int NC  = ROWS * COLS;
    localparam int IW  = (NC < 2) ? 1 : $clog2(NC);

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_LEFT  = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    // Off-map columns are the tunnel mouth when wrapping is on; off-map rows are solid.
    function automatic logic wall_at(input int row, input int col, input logic [NC-1:0] walls);
        logic [IW-1:0] idx;
        logic          w;
        idx = IW'(row * COLS + col);
        if (row < 0 || row >= ROWS) begin
            w = 1'b1;
        end else if (col < 0 || col >= COLS) begin
            w = (WRAP_EN == 0);
        end else begin
            w = walls[idx];
        end
        return w;
    endfunction

    // Arithmetic shift floors negative offsets so they land on row/col -1, not 0.
    function automatic logic is_free(input logic [1:0] d, input logic [9:0] x,
                                     input logic [9:0] y, input logic [NC-1:0] walls);
        int ax, ay, r0, r1, c0, c1;
        ax = int'(x) - X_OFF;
        ay = int'(y) - Y_OFF;
        r0 = ay >>> TSH;
        r1 = (ay + TILE - 1) >>> TSH;
        c0 = ax >>> TSH;
        c1 = (ax + TILE - 1) >>> TSH;
        case (d)
            D_UP:    begin r0 = (ay - STEP) >>> TSH;            r1 = r0; end
            D_DOWN:  begin r0 = (ay + STEP + TILE - 1) >>> TSH; r1 = r0; end
            D_LEFT:  begin c0 = (ax - STEP) >>> TSH;            c1 = c0; end
            default: begin c0 = (ax + STEP + TILE - 1) >>> TSH; c1 = c0; end
        endcase
        return !(wall_at(r0, c0, walls) || wall_at(r1, c1, walls));
    endfunction

    logic [9:0]    xpos_q, xpos_d, ypos_q, ypos_d;
    logic [1:0]    dir_q, dir_d, pdir_q, pdir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          move_q, move_d, pend_q, pend_d, wrap_q, wrap_d;
    logic          key_vld_s, req_vld_s, take_s, go_s;
    logic [1:0]    key_dir_s, req_dir_s, go_dir_s;

    // Keycode decode.
    always_comb begin
        key_vld_s = 1'b1;
        key_dir_s = D_UP;
        case (keycode)
            8'h1A:   key_dir_s = D_UP;
            8'h04:   key_dir_s = D_LEFT;
            8'h16:   key_dir_s = D_DOWN;
            8'h07:   key_dir_s = D_RIGHT;
            default: key_vld_s = 1'b0;
        endcase
    end

    // Request selection, pending bookkeeping and next position.
    always_comb begin
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        dir_d     = dir_q;
        pdir_d    = pdir_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        move_d    = 1'b0;
        wrap_d    = 1'b0;
        take_s    = 1'b0;
        go_s      = 1'b0;
        go_dir_s  = dir_q;
        req_vld_s = key_vld_s || pend_q;
        req_dir_s = key_vld_s ? key_dir_s : pdir_q;
        if (enable) begin
            take_s = req_vld_s && is_free(req_dir_s, xpos_q, ypos_q, maze_walls);
            if (take_s) begin
                go_s     = 1'b1;
                go_dir_s = req_dir_s;
                dir_d    = req_dir_s;
                pend_d   = 1'b0;
                cnt_d    = '0;
            end else begin
                go_s = is_free(dir_q, xpos_q, ypos_q, maze_walls);
                if (key_vld_s) begin
                    pdir_d = key_dir_s;
                    cnt_d  = CW'(TURN_HOLD);
                    pend_d = (TURN_HOLD != 0);
                end else if (cnt_q != '0) begin
                    cnt_d  = cnt_q - CW'(1);
                    pend_d = pend_q && (cnt_q != CW'(1));
                end else begin
                    pend_d = 1'b0;
                end
            end
            if (go_s) begin
                move_d = 1'b1;
                case (go_dir_s)
                    D_UP:   ypos_d = ypos_q - 10'(STEP);
                    D_DOWN: ypos_d = ypos_q + 10'(STEP);
                    D_LEFT: begin
                        if (WRAP_EN != 0 && xpos_q == 10'(WRAP_LO)) begin
                            xpos_d = 10'(WRAP_HI);
                            wrap_d = 1'b1;
                        end else begin
                            xpos_d = xpos_q - 10'(STEP);
                        end
                    end
                    default: begin
                        if (WRAP_EN != 0 && xpos_q == 10'(WRAP_HI)) begin
                            xpos_d = 10'(WRAP_LO);
                            wrap_d = 1'b1;
                        end else begin
                            xpos_d = xpos_q + 10'(STEP);
                        end
                    end
                endcase
            end else begin
                move_d = 1'b0;
            end
        end else begin
            move_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            xpos_q <= 10'(START_X);
            ypos_q <= 10'(START_Y);
            dir_q  <= 2'(START_DIR);
            pdir_q <= 2'd0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            move_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            xpos_q <= xpos_d;
            ypos_q <= ypos_d;
            dir_q  <= dir_d;
            pdir_q <= pdir_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            move_q <= move_d;
            wrap_q <= wrap_d;
        end
    end

    assign xpos         = xpos_q;
    assign ypos         = ypos_q;
    assign curDir       = {1'b0, dir_q};
    assign move         = move_q;
    assign turn_pending = pend_q;
    assign wrapped      = wrap_q;

endmodule

// File: doc/maze_mover.md
Name: maze_mover

Overview:
Parametrised player-movement engine for the maze game. It advances a TILE-square sprite through a tile maze once per frame_clk, reads the wall bitmap from the shared maze source, and supports configurable step size and horizontal tunnel wrap. A new feature is a buffered ("pre-turn") direction request: a key pressed slightly before a junction is remembered for TURN_HOLD frames and taken as soon as the path opens. Outputs feed the sprite renderer, the animation block and the collision logic.

Parameters:
TILE, 16, tile edge in pixels; power of two; sprite is TILE x TILE
COLS, 30, maze columns
ROWS, 30, maze rows
X_OFF, 32, screen x of maze column 0
Y_OFF, 0, screen y of maze row 0
START_X, 272, xpos after reset
START_Y, 368, ypos after reset
START_DIR, 3, curDir after reset
STEP, 1, pixels per move; must divide TILE
TURN_HOLD, 8, frames a blocked request stays pending; 0 means no buffering
WRAP_EN, 1, enables the horizontal tunnel
WRAP_LO, 16, left tunnel x; moving left from here jumps to WRAP_HI
WRAP_HI, 512, right tunnel x; moving right from here jumps to WRAP_LO

Ports:
Reset  in  1  asynchronous, active-high
frame_clk  in  1  frame clock; one evaluation per rising edge
enable  in  1  1 = run; 0 = freeze position, pending state and hold counter
keycode  in  8  HID code: 0x1A up, 0x04 left, 0x16 down, 0x07 right; all other codes are no request
maze_walls  in  ROWS*COLS  bit r*COLS+c = 1 means a wall at row r, column c
xpos  out  10  sprite top-left x, pixels
ypos  out  10  sprite top-left y, pixels
curDir  out  3  direction: 0 up, 1 left, 2 down, 3 right
move  out  1  1 = position changed this frame
turn_pending  out  1  a buffered request is held
wrapped  out  1  one-frame pulse on a tunnel jump

Behaviour:
- Reset (async): xpos=START_X, ypos=START_Y, curDir=START_DIR, move=0, turn_pending=0, hold counter=0, pending dir=0, wrapped=0.
- All outputs are registered; updates take effect on the frame_clk edge after the inputs are sampled (1-frame latency).
- free(d) test, combinational, computed on the box moved STEP pixels in direction d:
  - Up checks the row of (ypos-STEP-Y_OFF)/TILE at both column edges, (xpos-X_OFF)/TILE and (xpos-X_OFF+TILE-1)/TILE.
  - Down, left and right are analogous; each checks the two corner cells of the leading edge.
- Out-of-range cells:
  - Column <0 or >=COLS is open if WRAP_EN=1, else a wall.
  - Row out of range is always a wall.
  - Signed arithmetic must be at least 12 bits so that negative offsets are detected and do not alias.
- Request selection per frame (enable=1):
  - req = the key direction if keycode is valid; else the pending direction if turn_pending=1; else none.
  - If req exists and free(req): curDir<=req, step in req, move=1, turn_pending<=0.
  - Else if free(curDir): step in curDir, move=1.
  - Else: move=0; position and curDir are held.
- Pending update when the request was not taken:
  - Valid key: pending dir<=key, counter<=TURN_HOLD, turn_pending<=(TURN_HOLD!=0).
  - No key: counter decrements; turn_pending clears on the frame the counter reaches 0.
- A key for the current direction is treated like any other request. It is taken if free, so pending clears.
- Reversal needs no special case: the reverse direction is free by construction.
- Step: the position changes by STEP in the chosen axis. STEP alignment is preserved because START_X-X_OFF and START_Y-Y_OFF are multiples of STEP.
- Wrap (WRAP_EN=1):
  - Moving left with xpos==WRAP_LO: xpos<=WRAP_HI, wrapped=1.
  - Moving right with xpos==WRAP_HI: xpos<=WRAP_LO, wrapped=1.
  - wrapped=0 on every other frame.
- enable=0: move=0 and wrapped=0. Position, curDir, pending dir and counter are all held. Keys are ignored.
- Reset mid-move or with a request pending: everything returns to its reset values immediately; no request survives.
- maze_walls may change between frames; each frame uses the current value.

Test Plan:
- Reset, keycode=0, straight open corridor (START 272,368, dir 3): 5 frames -> xpos 273..277, ypos 368, move=1 every frame.
- Reset, keycode=0, wall directly ahead of the sprite: 3 frames -> xpos and ypos unchanged, move=0, curDir=3.
- Key 0x1A pressed for 1 frame, 4 px before an up-junction, TURN_HOLD=8:
  - turn_pending=1 for 4 frames while the sprite continues right.
  - The 5th frame takes the turn: curDir=0, ypos-1, turn_pending=0.
- Same case with the junction 10 px away -> pending expires after 8 frames; the sprite continues right and never turns.
- Tunnel row, xpos=WRAP_LO, dir left, free -> next xpos=512 with wrapped=1 for 1 frame. Then from xpos=512 moving right -> xpos=16.
- enable=0 for 3 frames with key 0x04 held -> xpos, ypos, curDir and the hold counter are frozen, move=0. Assert Reset mid-sequence -> outputs return to 272,368, dir 3, turn_pending=0.
